// File: rtl/dm_resp_if.sv
// dm_resp_if: load/store bus between the core's memory stage (master)
// and the data-memory responder (slave).
//   req/we/bmode/addr/wdata : request strobe and access attributes (master -> slave)
//   rdata/ready/err         : response, valid for the one-cycle ready pulse
//   busy/ovf                : responder status (busy = access in flight, ovf = sticky drop flag)
interface dm_resp_if;
  logic        req;
  logic        we;
  logic        bmode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;
  logic        ovf;

  modport master (
    output req, we, bmode, addr, wdata,
    input  rdata, ready, busy, err, ovf
  );

  modport slave (
    input  req, we, bmode, addr, wdata,
    output rdata, ready, busy, err, ovf
  );
endinterface

// File: rtl/dm_resp.sv
// dm_resp: multi-cycle data-memory responder for the multi-cycle MIPS core.
// Accepts one word/byte load or store per req strobe, inserts LATENCY wait
// states, performs the access into an internal 2^ADDR_W-word array and
// answers with a one-cycle ready pulse (byte loads sign-extended).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dm_resp_if.slave (req, we, bmode, addr, wdata -> rdata, ready,
//          busy, err, ovf)
// Parameters: ADDR_W (word-address width), LATENCY (0..15 wait states).
// Build option: define DM_RESP_BYTE_EN to enable byte accesses (LB/SB);
// without it bmode is ignored and every access is a word access.
module dm_resp #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input logic     clk,
  input logic     rst,
  dm_resp_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [3:0]        cnt;
  logic              a_we;
  logic [ADDR_W+1:0] a_addr;
  logic [31:0]       a_wdata;
`ifdef DM_RESP_BYTE_EN
  logic              a_byte;
`endif

  logic [ADDR_W-1:0] a_wa;
  logic [1:0]        a_lane;
  logic              a_mis;
  logic              accept;
  logic              access;
  logic              busy_c;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [31:0]       load_data;

  logic [31:0]       rdata_q;
  logic              ready_q;
  logic              err_q;
  logic              ovf_q;

  logic [31:0]       mem [2**ADDR_W];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. Acceptance always passes through WAIT, so LATENCY=0
  // still spends one cycle there: request-to-ready is LATENCY+2 cycles.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.req) state_next = WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    accept = (state == IDLE) && bus.req;
    access = (state == WAIT) && (cnt == '0);  // edge that enters RESP
    busy_c = (state != IDLE);
  end

  assign a_wa   = a_addr[ADDR_W+1:2];
  assign a_lane = a_addr[1:0];

`ifdef DM_RESP_BYTE_EN
  assign a_mis = !a_byte && (a_lane != 2'b00);
`else
  assign a_mis = (a_lane != 2'b00);
`endif

  // Load path
  always_comb begin
    rd_word = mem[a_wa];
    unique case (a_lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    if (a_mis)
      load_data = '0;
`ifdef DM_RESP_BYTE_EN
    else if (a_byte)
      load_data = {{24{rd_byte[7]}}, rd_byte};
`endif
    else
      load_data = rd_word;
  end

  // Request latch, wait counter and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      a_we    <= 1'b0;
      a_addr  <= '0;
      a_wdata <= '0;
`ifdef DM_RESP_BYTE_EN
      a_byte  <= 1'b0;
`endif
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ready_q <= access;
      err_q   <= access && a_mis;
      if (accept) begin
        a_we    <= bus.we;
        a_addr  <= bus.addr[ADDR_W+1:0];
        a_wdata <= bus.wdata;
`ifdef DM_RESP_BYTE_EN
        a_byte  <= bus.bmode;
`endif
        cnt     <= 4'(LATENCY);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (bus.req && busy_c) ovf_q <= 1'b1;
      if (access) rdata_q <= load_data;
    end
  end

  // Storage array: not cleared by reset; a reset on the access edge
  // abandons the store.
  always_ff @(posedge clk) begin
    if (!rst && access && a_we && !a_mis) begin
`ifdef DM_RESP_BYTE_EN
      if (a_byte) mem[a_wa][{a_lane, 3'b000} +: 8] <= a_wdata[7:0];
      else        mem[a_wa] <= a_wdata;
`else
      mem[a_wa] <= a_wdata;
`endif
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = busy_c;

endmodule

// File: tb/tb_dm_resp.sv
// tb_dm_resp: scoreboard bench for dm_resp. Two instances: LATENCY=2 and
// LATENCY=0 (both ADDR_W=10). Expected responses are pushed when a request
// is driven and popped when ready is observed.
module tb_dm_resp;

`ifdef DM_RESP_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk;
    int          lat;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t        q2[$];
  exp_t        q0[$];
  logic [31:0] m2 [1024];
  logic [31:0] m0 [1024];

  dm_resp_if b2();
  dm_resp_if b0();

  dm_resp #(.ADDR_W(10), .LATENCY(2)) dut (.clk(clk), .rst(rst), .bus(b2));
  dm_resp #(.ADDR_W(10), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input bit d, input logic r, input logic w, input logic bm,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d) begin
      b0.req = r; b0.we = w; b0.bmode = bm; b0.addr = a; b0.wdata = wd;
    end else begin
      b2.req = r; b2.we = w; b2.bmode = bm; b2.addr = a; b2.wdata = wd;
    end
  endtask

  task automatic mon(input bit d, input logic rdy, input logic [31:0] rd, input logic er);
    exp_t e;
    if ((d ? q0.size() : q2.size()) == 0) begin
      check_eq(d ? "spurious_ready_l0" : "spurious_ready_l2", {31'b0, rdy}, 32'd0);
      return;
    end
    e = d ? q0.pop_front() : q2.pop_front();
    check_eq(d ? "err_l0" : "err_l2", {31'b0, er}, {31'b0, e.err});
    if (e.chk) check_eq(d ? "rdata_l0" : "rdata_l2", rd, e.rdata);
    check_eq(d ? "latency_l0" : "latency_l2", 32'(cyc - e.t0), 32'(e.lat));
  endtask

  always @(negedge clk) begin
    if (b2.ready) mon(1'b0, b2.ready, b2.rdata, b2.err);
    if (b0.ready) mon(1'b1, b0.ready, b0.rdata, b0.err);
  end

  // Drive one request for a single cycle and push its expected response.
  task automatic issue_start(input bit d, input logic w, input logic bm,
                             input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    logic [9:0]  wa;
    logic [1:0]  lane;
    logic        byt;
    logic        mis;
    logic [31:0] word;
    logic [7:0]  bb;
    wa   = a[11:2];
    lane = a[1:0];
    byt  = BYTE_EN && bm;
    mis  = !byt && (lane != 2'b00);
    word = d ? m0[wa] : m2[wa];
    e.err   = mis;
    e.chk   = !w || mis;
    e.rdata = '0;
    e.lat   = d ? 2 : 4;
    if (!mis) begin
      if (w) begin
        if (byt) word[lane*8 +: 8] = wd[7:0];
        else     word = wd;
        if (d) m0[wa] = word;
        else   m2[wa] = word;
      end else if (byt) begin
        bb = word[lane*8 +: 8];
        e.rdata = {{24{bb[7]}}, bb};
      end else begin
        e.rdata = word;
      end
    end
    @(posedge clk); #1;
    drive(d, 1'b1, w, bm, a, wd);
    e.t0 = cyc;
    if (d) q0.push_back(e);
    else   q2.push_back(e);
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wait_done(input bit d);
    for (int i = 0; i < 40; i++) begin
      if ((d ? q0.size() : q2.size()) == 0) break;
      @(negedge clk); #1;
    end
    if ((d ? q0.size() : q2.size()) != 0) begin
      check_eq("ready_timeout", 32'(d ? q0.size() : q2.size()), 32'd0);
      if (d) q0.delete();
      else   q2.delete();
    end
  endtask

  task automatic acc(input bit d, input logic w, input logic bm,
                     input logic [31:0] a, input logic [31:0] wd);
    issue_start(d, w, bm, a, wd);
    wait_done(d);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_eq("rst_rdata", b2.rdata, 32'h0);
    check_eq("rst_ready", {31'b0, b2.ready}, 32'd0);
    check_eq("rst_busy",  {31'b0, b2.busy},  32'd0);
    check_eq("rst_err",   {31'b0, b2.err},   32'd0);
    check_eq("rst_ovf",   {31'b0, b2.ovf},   32'd0);
    check_eq("rst_busy_l0", {31'b0, b0.busy}, 32'd0);

    // Word store then load
    acc(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    acc(1'b0, 1'b0, 1'b0, 32'h10, 32'h0);

    // Byte store and sign extension
    acc(1'b0, 1'b1, 1'b0, 32'h20, 32'h11223344);
    acc(1'b0, 1'b1, 1'b1, 32'h21, 32'h000000F0);
    acc(1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
    acc(1'b0, 1'b0, 1'b1, 32'h21, 32'h0);
    acc(1'b0, 1'b0, 1'b1, 32'h23, 32'h0);

    // Misaligned word accesses
    acc(1'b0, 1'b0, 1'b0, 32'h22, 32'h0);
    acc(1'b0, 1'b1, 1'b0, 32'h22, 32'h55555555);
    acc(1'b0, 1'b0, 1'b0, 32'h20, 32'h0);

    // Request while busy is dropped and sets ovf
    acc(1'b0, 1'b1, 1'b0, 32'h44, 32'hA5A5A5A5);
    issue_start(1'b0, 1'b1, 1'b0, 32'h40, 32'hCAFEF00D);
    check_eq("busy_in_wait", {31'b0, b2.busy}, 32'd1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0BAD0BAD);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("ovf_set", {31'b0, b2.ovf}, 32'd1);
    wait_done(1'b0);
    acc(1'b0, 1'b0, 1'b0, 32'h40, 32'h0);   // request in the cycle after ready
    acc(1'b0, 1'b0, 1'b0, 32'h44, 32'h0);
    check_eq("ovf_sticky", {31'b0, b2.ovf}, 32'd1);

    // Reset during WAIT abandons the store
    acc(1'b0, 1'b1, 1'b0, 32'h30, 32'h11111111);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h12345678);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("busy_before_abort", {31'b0, b2.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("busy_after_abort", {31'b0, b2.busy}, 32'd0);
    check_eq("ovf_cleared", {31'b0, b2.ovf}, 32'd0);
    repeat (6) @(posedge clk);
    acc(1'b0, 1'b0, 1'b0, 32'h30, 32'h0);

    // Reset wins over a simultaneous request
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h87654321);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("busy_rst_req", {31'b0, b2.busy}, 32'd0);
    repeat (6) @(posedge clk);
    acc(1'b0, 1'b0, 1'b0, 32'h30, 32'h0);

    // LATENCY=0 and address wrap
    acc(1'b1, 1'b1, 1'b0, 32'h1000, 32'h0F1E2D3C);
    acc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    acc(1'b1, 1'b0, 1'b0, 32'h1000, 32'h0);
    acc(1'b1, 1'b0, 1'b0, 32'h1002, 32'h0);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
